seven_seg_scan_decoder: RTL and testbench
=========================================

// Module: seven_seg_scan_decoder
// PURPOSE
//   Receive side of the multiplexed 7-seg display bus: snoops anode-select + segment lines driven
//   toward the clock's display and reconstructs the BCD digit and DP state of every position.
//   Used for display readback/self-check and as a bench monitor; runs in the system clock domain.
//   Emits a full frame once every digit position has been seen stable.
// PARAMETERS
//   DIGITS  4  number of multiplexed digit positions (2..8)
//   SETTLE  2  consecutive identical samples required before a digit is captured (1..15)
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   rst          in   1           synchronous, active-high reset
//   an           in   DIGITS      anode select, active-low; exactly one bit low = that digit driven
//   seg          in   8           active-low segments {a,b,c,d,e,f,g,dp}; seg[7]=a .. seg[1]=g, seg[0]=dp
//   digits       out  4*DIGITS    decoded BCD, digit i in digits[4i+3:4i]; 4'hF = undecodable
//   dp_out       out  DIGITS      dp_out[i]=1 when digit i decimal point lit (seg[0]=0)
//   frame_valid  out  1           1-cycle pulse: digits/dp_out/frame_err just updated
//   frame_err    out  1           valid with frame_valid: >=1 digit in frame was undecodable
//   an_err       out  1           sticky: an seen with >1 bit low; cleared only by rst
// BEHAVIOUR
//   - Reset: digits=0, dp_out=0, frame_valid=0, frame_err=0, an_err=0, sample regs=all-ones,
//     stable count=0, seen mask=0, shadow regs=0.
//   - Stage 1: an/seg registered every cycle (s_an, s_seg); prior sample kept (p_an, p_seg).
//   - Stability: cnt increments (saturating at SETTLE) when {s_an,s_seg}=={p_an,p_seg} and s_an is
//     one-hot-low; any difference or non-one-hot s_an resets cnt to 0.
//   - Capture: when count of identical samples reaches SETTLE (cnt==SETTLE-1 and still equal),
//     digit i selected by s_an is written to shadow[i], dp to shadow_dp[i], seen[i] set. Shadow
//     keeps updating each cycle while stable (last value wins).
//   - Latency: inputs steady from before edge k -> first sample at k, capture at edge k+SETTLE.
//   - Decode of s_seg[7:1]: 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//     0100000=6 0001111=7 0000000=8 0000100=9; any other -> 4'hF and shadow_err[i]=1.
//   - Frame: on the capture edge that makes seen all-ones (capture value included), shadow ->
//     digits/dp_out, frame_err=OR of shadow_err, frame_valid=1 for that cycle; seen and shadow_err
//     cleared same edge. Outputs hold between frames.
//   - an all-ones (blanking): ignored, cnt=0, no error. an with >=2 bits low: ignored, cnt=0,
//     an_err set.
//   - Position order irrelevant; repeat of an already-seen digit only overwrites its shadow.
//   - rst mid-frame: partial frame discarded, outputs return to reset values next edge.
// TESTING
//   1 rst held 3 cycles with random an/seg -> all outputs 0, no frame_valid.
//   2 scan digits 0..3 = 1,2,3,4, each held 4 cycles, dp lit on digit 2 -> one frame_valid,
//     digits=16'h4321, dp_out=4'b0100, frame_err=0.
//   3 digit 1 pattern changed for 1 cycle (< SETTLE) mid-hold, then restored -> no corruption;
//     digits unchanged from stable value.
//   4 digit 3 drives seg=8'hFF (blank) in full frame of 5,6,7 -> digits[15:12]=4'hF, frame_err=1.
//   5 an=4'b1111 for 10 cycles then an=4'b1100 for 5 cycles -> no capture, an_err=1 and stays 1.
//   6 rst asserted after 2 of 4 digits captured, then full scan of 9,8,0,7 -> single frame,
//     digits=16'h7089, no stale values.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the BCD digit and DP of every
// position. Publishes a complete frame once each position has been captured while stable.
module seven_seg_scan_decoder #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an,
    input  logic [7:0]            seg,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  an_err
);

    localparam logic [DIGITS-1:0] Lsb = DIGITS'(1);

    logic [DIGITS-1:0]      s_an;
    logic [7:0]             s_seg;
    logic [3:0]             cnt;
    logic [DIGITS-1:0]      seen;
    logic [DIGITS-1:0][3:0] shadow;
    logic [DIGITS-1:0]      shadow_dp;
    logic [DIGITS-1:0]      shadow_err;

    logic [DIGITS-1:0]      sel;
    logic                   one_hot;
    logic                   multi_low;
    logic                   same;
    logic                   stable;
    logic                   cap;
    logic                   frame;
    logic [3:0]             dec;
    logic                   dec_err;
    logic [3:0]             cnt_d;
    logic [DIGITS-1:0]      seen_d;
    logic [DIGITS-1:0][3:0] shadow_d;
    logic [DIGITS-1:0]      shadow_dp_d;
    logic [DIGITS-1:0]      shadow_err_d;

    // The registered sample is the "prior" copy for the incoming value, so a match here means
    // the next sample pair will be identical; this gives capture exactly SETTLE edges after
    // the first sample of a steady input.
    always_comb begin
        sel       = ~s_an;
        multi_low = (sel & (sel - Lsb)) != '0;
        one_hot   = (sel != '0) && !multi_low;
        same      = (an == s_an) && (seg == s_seg);
        stable    = same && one_hot;
        cap       = stable && (cnt >= 4'(SETTLE - 1));
    end

    always_comb begin
        dec_err = 1'b0;
        unique case (s_seg[7:1])
            7'b0000001: dec = 4'd0;
            7'b1001111: dec = 4'd1;
            7'b0010010: dec = 4'd2;
            7'b0000110: dec = 4'd3;
            7'b1001100: dec = 4'd4;
            7'b0100100: dec = 4'd5;
            7'b0100000: dec = 4'd6;
            7'b0001111: dec = 4'd7;
            7'b0000000: dec = 4'd8;
            7'b0000100: dec = 4'd9;
            default: begin
                dec     = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        cnt_d        = 4'd0;
        seen_d       = seen;
        shadow_d     = shadow;
        shadow_dp_d  = shadow_dp;
        shadow_err_d = shadow_err;
        if (stable) begin
            cnt_d = (cnt < 4'(SETTLE)) ? cnt + 4'd1 : cnt;
        end
        if (cap) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (sel[i]) begin
                    shadow_d[i]     = dec;
                    shadow_dp_d[i]  = ~s_seg[0];
                    shadow_err_d[i] = dec_err;
                    seen_d[i]       = 1'b1;
                end
            end
        end
        frame = cap && (&seen_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an        <= '1;
            s_seg       <= '1;
            cnt         <= 4'd0;
            seen        <= '0;
            shadow      <= '0;
            shadow_dp   <= '0;
            shadow_err  <= '0;
            digits      <= '0;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            s_an        <= an;
            s_seg       <= seg;
            cnt         <= cnt_d;
            shadow      <= shadow_d;
            shadow_dp   <= shadow_dp_d;
            frame_valid <= frame;
            if (multi_low) begin
                an_err <= 1'b1;
            end
            if (frame) begin
                digits     <= shadow_d;
                dp_out     <= shadow_dp_d;
                frame_err  <= |shadow_err_d;
                seen       <= '0;
                shadow_err <= '0;
            end else begin
                seen       <= seen_d;
                shadow_err <= shadow_err_d;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: scenarios push expected frames, a negedge monitor pops and compares on
// every frame_valid pulse.
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        frame_err;
    logic        an_err;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic        err;
    } frame_t;

    frame_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    seven_seg_scan_decoder #(.DIGITS(4), .SETTLE(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] segs(input int d, input bit dp);
        logic [7:0] v;
        case (d)
            0: v = 8'h03;
            1: v = 8'h9F;
            2: v = 8'h25;
            3: v = 8'h0D;
            4: v = 8'h99;
            5: v = 8'h49;
            6: v = 8'h41;
            7: v = 8'h1F;
            8: v = 8'h01;
            9: v = 8'h09;
            default: v = 8'hFF;
        endcase
        if (dp) v[0] = 1'b0;
        return v;
    endfunction

    // Called at a negedge; holds the position for n cycles.
    task automatic hold(input int pos, input logic [7:0] s, input int n);
        an  = ~(4'b0001 << pos);
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        an  = 4'hF;
        seg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        an  = 4'hF;
        seg = 8'hFF;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] dp, input logic err);
        frame_t f;
        f.d   = d;
        f.dp  = dp;
        f.err = err;
        exp_q.push_back(f);
    endtask

    always @(negedge clk) begin
        frame_t e;
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got digits=%h expected no frame", digits);
            end else begin
                e = exp_q.pop_front();
                check("frame_digits", 32'(digits), 32'(e.d));
                check("frame_dp", 32'(dp_out), 32'(e.dp));
                check("frame_err", 32'(frame_err), 32'(e.err));
            end
        end
    end

    initial begin
        // 1: reset with random bus activity
        rst = 1'b1;
        an  = 4'($urandom);
        seg = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            an  = 4'($urandom);
            seg = 8'($urandom);
        end
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_an_err", 32'(an_err), 32'h0);
        rst = 1'b0;
        blank(3);

        // 2: clean scan 1,2,3,4 with dp on digit 2
        push(16'h4321, 4'b0100, 1'b0);
        hold(0, segs(1, 0), 4);
        hold(1, segs(2, 0), 4);
        hold(2, segs(3, 1), 4);
        hold(3, segs(4, 0), 4);
        blank(4);
        check("scan_frame_seen", 32'(exp_q.size()), 32'h0);
        do_reset(2);

        // 3: one-cycle glitch on digit 1 must not be captured
        push(16'h4321, 4'b0000, 1'b0);
        hold(0, segs(1, 0), 4);
        hold(1, segs(2, 0), 2);
        hold(1, segs(8, 0), 1);
        hold(1, segs(2, 0), 4);
        hold(2, segs(3, 0), 4);
        hold(3, segs(4, 0), 4);
        blank(4);
        check("glitch_frame_seen", 32'(exp_q.size()), 32'h0);
        do_reset(2);

        // 4: blank pattern on digit 3 is undecodable
        push(16'hF765, 4'b0000, 1'b1);
        hold(0, segs(5, 0), 4);
        hold(1, segs(6, 0), 4);
        hold(2, segs(7, 0), 4);
        hold(3, 8'hFF, 4);
        blank(4);
        check("blank_frame_seen", 32'(exp_q.size()), 32'h0);

        // 5: blanking is ignored silently; two anodes low flags an_err
        check("an_err_clear", 32'(an_err), 32'h0);
        blank(10);
        check("an_err_after_blank", 32'(an_err), 32'h0);
        an  = 4'b1100;
        seg = segs(3, 0);
        repeat (5) @(negedge clk);
        blank(3);
        check("an_err_set", 32'(an_err), 32'h1);
        check("digits_held", 32'(digits), 32'hF765);
        blank(10);
        check("an_err_sticky", 32'(an_err), 32'h1);

        // 6: reset mid-frame discards partial captures
        hold(0, segs(5, 0), 4);
        hold(1, segs(5, 0), 4);
        check("an_err_before_rst", 32'(an_err), 32'h1);
        an  = 4'hF;
        seg = 8'hFF;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_an_err", 32'(an_err), 32'h0);
        rst = 1'b0;
        push(16'h7089, 4'b0000, 1'b0);
        hold(0, segs(9, 0), 4);
        hold(1, segs(8, 0), 4);
        hold(2, segs(0, 0), 4);
        hold(3, segs(7, 0), 4);
        blank(6);
        check("final_frame_seen", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
